// File: rtl/zsp_pkg.sv
// Shared types for the z stream packer.
// Words are stored at the maximum width so the FIFO type stays fixed.
package zsp_pkg;

    function automatic int lw(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int ZSP_MAX_W  = 32;
    localparam int ZSP_MAX_LW = lw(ZSP_MAX_W);

    typedef struct packed {
        logic [ZSP_MAX_W-1:0]  data;
        logic [ZSP_MAX_LW-1:0] len;
        logic [ZSP_MAX_LW-1:0] ones;
    } zsp_word_t;

endpackage

// File: rtl/zsp_fifo2.sv
// Two-entry synchronous FIFO of packed words.
// Head reads as zero while empty.
module zsp_fifo2
    import zsp_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  zsp_word_t din,
    input  logic      pop,
    output zsp_word_t dout,
    output logic      full,
    output logic      empty
);

    zsp_word_t  mem_q [2];
    zsp_word_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/z_stream_packer.sv
// Packs the single-bit z stream LSB-first into words with
// popcount and length, queued through a 2-entry output FIFO.
module z_stream_packer
    import zsp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int LW    = lw(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    out_len,
    output logic [LW-1:0]    out_ones,
    output logic             drop_err
);

    logic [WIDTH-1:0] data_q, data_d, nxt_data;
    logic [LW-1:0]    bit_cnt_q, bit_cnt_d, nxt_cnt;
    logic [LW-1:0]    ones_cnt_q, ones_cnt_d, nxt_ones;
    logic             flush_pend_q, flush_pend_d;
    logic             drop_err_q, drop_err_d;
    logic             accept, push, pop, full, empty;
    zsp_word_t        push_word, head;

    // Only registered state feeds in_ready; a same-cycle pop cannot raise it.
    assign in_ready = !flush_pend_q
                   && !(bit_cnt_q == LW'(WIDTH - 1) && full);
    assign accept   = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head.data[WIDTH-1:0];
    assign out_len   = head.len[LW-1:0];
    assign out_ones  = head.ones[LW-1:0];
    assign drop_err  = drop_err_q;

    always_comb begin
        nxt_data = data_q;
        nxt_cnt  = bit_cnt_q;
        nxt_ones = ones_cnt_q;
        if (accept) begin
            nxt_data = data_q | (WIDTH'(in_bit) << bit_cnt_q);
            nxt_cnt  = bit_cnt_q + LW'(1);
            nxt_ones = ones_cnt_q + LW'(in_bit);
        end
        data_d       = nxt_data;
        bit_cnt_d    = nxt_cnt;
        ones_cnt_d   = nxt_ones;
        flush_pend_d = flush_pend_q || flush;
        drop_err_d   = drop_err_q || (in_valid && !in_ready);
        push         = 1'b0;
        push_word    = '0;
        push_word.data[WIDTH-1:0] = nxt_data;
        push_word.len[LW-1:0]     = nxt_cnt;
        push_word.ones[LW-1:0]    = nxt_ones;
        if (accept && nxt_cnt == LW'(WIDTH)) begin
            push       = 1'b1;
            data_d     = '0;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
        end else if (flush_pend_q && !full) begin
            // An empty partial word just retires the flush.
            push         = (bit_cnt_q != '0);
            data_d       = '0;
            bit_cnt_d    = '0;
            ones_cnt_d   = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q       <= '0;
            bit_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            flush_pend_q <= flush_pend_d;
            drop_err_q   <= drop_err_d;
        end
    end

    zsp_fifo2 u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_word),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    logic unused_head;
    assign unused_head = ^head;

endmodule
